// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b, LSB first, one bit per clock,
// using a single borrow flop behind a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] sr_r;
  logic [WIDTH-1:0] diff_r;
  logic [CNT_W-1:0] cnt_r;
  logic             br_r;
  logic             borrow_r;
  logic             busy_r;
  logic             done_r;

  logic             x_s;
  logic             y_s;
  logic             d_s;
  logic             br_nxt_s;
  logic             last_s;
  logic [WIDTH-1:0] sr_nxt_s;

  // One-bit full-subtractor slice on the current LSBs
  always_comb begin
    x_s      = sa_r[0];
    y_s      = sb_r[0];
    d_s      = x_s ^ y_s ^ br_r;
    br_nxt_s = (~x_s & y_s) | (~(x_s ^ y_s) & br_r);
    sr_nxt_s = {d_s, sr_r[WIDTH-1:1]};
    last_s   = (cnt_r == LAST_CNT);
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Operand shifters, borrow, bit counter and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_r     <= '0;
      sb_r     <= '0;
      sr_r     <= '0;
      br_r     <= 1'b0;
      cnt_r    <= '0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            sa_r  <= a;
            sb_r  <= b;
            br_r  <= 1'b0;
            cnt_r <= '0;
          end
        end
        ST_RUN: begin
          sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
          sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
          sr_r  <= sr_nxt_s;
          br_r  <= br_nxt_s;
          cnt_r <= cnt_r + CNT_W'(1);
          // Published results move only on the edge that finishes the MSB
          if (last_s) begin
            diff_r   <= sr_nxt_s;
            borrow_r <= br_nxt_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign diff       = diff_r;
  assign borrow_out = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: three lanes (WIDTH 8, 2, 32), each with
// an arithmetic reference model feeding a queue that a negedge monitor drains.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_v [3];
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];

  int checks = 0;
  int errors = 0;

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input int lane, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d: got 0x%0h expected 0x%0h", nm, lane, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    localparam int W = (gi == 0) ? 8 : ((gi == 1) ? 2 : 32);

    logic          busy_l;
    logic          done_l;
    logic          bo_l;
    logic [W-1:0]  diff_l;
    logic [W-1:0]  hold_d = '0;
    logic          hold_bo = 1'b0;
    logic [31:0]   qd [$];
    logic          qbo [$];
    int            qa [$];
    int            cyc = 0;
    int            acc_cnt = 0;
    int            last_acc = 0;
    int            next_ok = 0;
    longint        ua;
    longint        ub;
    longint        m;
    logic          eb;
    logic          ed;

    serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_v[gi]),
      .a          (a_v[gi][W-1:0]),
      .b          (b_v[gi][W-1:0]),
      .busy       (busy_l),
      .done       (done_l),
      .diff       (diff_l),
      .borrow_out (bo_l)
    );

    // Reference model: an idle unit accepts start, then is unavailable for W+2 edges
    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        qd.delete();
        qbo.delete();
        qa.delete();
        next_ok = cyc;
      end else begin
        cyc = cyc + 1;
        if (start_v[gi] && cyc >= next_ok) begin
          ua = longint'(a_v[gi][W-1:0]);
          ub = longint'(b_v[gi][W-1:0]);
          m  = longint'(1) << W;
          qd.push_back(32'((ua - ub + m) % m));
          qbo.push_back(ua < ub);
          qa.push_back(cyc);
          last_acc = cyc;
          acc_cnt++;
          next_ok = cyc + W + 2;
        end
      end
    end

    // Monitor: busy/done timing every cycle, results on done, stable otherwise
    initial forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_d  = '0;
        hold_bo = 1'b0;
      end else begin
        eb = 1'b0;
        ed = 1'b0;
        if (qa.size() > 0) begin
          eb = (cyc >= qa[0]) && (cyc < qa[0] + W);
          ed = (cyc == qa[0] + W);
        end
        chk("busy", gi, 64'(busy_l), 64'(eb));
        chk("done", gi, 64'(done_l), 64'(ed));
        if (ed) begin
          chk("diff", gi, 64'(diff_l), 64'(qd[0]));
          chk("borrow_out", gi, 64'(bo_l), 64'(qbo[0]));
          hold_d  = W'(qd[0]);
          hold_bo = qbo[0];
          void'(qd.pop_front());
          void'(qbo.pop_front());
          void'(qa.pop_front());
        end else begin
          chk("diff_hold", gi, 64'(diff_l), 64'(hold_d));
          chk("borrow_hold", gi, 64'(bo_l), 64'(hold_bo));
        end
      end
    end
  end

  function automatic int cyc_of(input int lane);
    case (lane)
      0:       cyc_of = g_lane[0].cyc;
      1:       cyc_of = g_lane[1].cyc;
      default: cyc_of = g_lane[2].cyc;
    endcase
  endfunction

  function automatic int acc_of(input int lane);
    case (lane)
      0:       acc_of = g_lane[0].acc_cnt;
      1:       acc_of = g_lane[1].acc_cnt;
      default: acc_of = g_lane[2].acc_cnt;
    endcase
  endfunction

  function automatic int last_of(input int lane);
    case (lane)
      0:       last_of = g_lane[0].last_acc;
      1:       last_of = g_lane[1].last_acc;
      default: last_of = g_lane[2].last_acc;
    endcase
  endfunction

  function automatic int qn_of(input int lane);
    case (lane)
      0:       qn_of = g_lane[0].qa.size();
      1:       qn_of = g_lane[1].qa.size();
      default: qn_of = g_lane[2].qa.size();
    endcase
  endfunction

  function automatic logic [34:0] outs_of(input int lane);
    case (lane)
      0:       outs_of = {g_lane[0].busy_l, g_lane[0].done_l, g_lane[0].bo_l, 32'(g_lane[0].diff_l)};
      1:       outs_of = {g_lane[1].busy_l, g_lane[1].done_l, g_lane[1].bo_l, 32'(g_lane[1].diff_l)};
      default: outs_of = {g_lane[2].busy_l, g_lane[2].done_l, g_lane[2].bo_l, 32'(g_lane[2].diff_l)};
    endcase
  endfunction

  task automatic issue(input int lane, input logic [31:0] av, input logic [31:0] bv, input bit keep);
    int n0;
    n0 = acc_of(lane);
    @(negedge clk);
    a_v[lane]     = av;
    b_v[lane]     = bv;
    start_v[lane] = 1'b1;
    for (int i = 0; i < 60 && acc_of(lane) == n0; i++) @(negedge clk);
    if (acc_of(lane) == n0) begin
      checks++;
      errors++;
      $display("FAIL accept lane%0d: no accept within 60 cycles", lane);
    end
    if (!keep) start_v[lane] = 1'b0;
  endtask

  task automatic wait_cyc(input int lane, input int target);
    for (int i = 0; i < 100 && cyc_of(lane) < target; i++) @(negedge clk);
  endtask

  task automatic drain(input int lane);
    for (int i = 0; i < 100 && qn_of(lane) != 0; i++) @(negedge clk);
    if (qn_of(lane) != 0) begin
      checks++;
      errors++;
      $display("FAIL drain lane%0d: %0d results still pending", lane, qn_of(lane));
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      a_v[k]     = 32'd0;
      b_v[k]     = 32'd0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) chk("reset_outs", k, 64'(outs_of(k)), 64'd0);
    #2 rst_n = 1'b1;

    // Directed WIDTH=8 cases, including borrow and wrap-around
    issue(0, 32'h05, 32'h03, 1'b0);
    issue(0, 32'h03, 32'h05, 1'b0);
    issue(0, 32'h00, 32'h01, 1'b0);
    issue(0, 32'hFF, 32'hFF, 1'b0);
    drain(0);

    // Start pulses during RUN and DONE must be ignored
    issue(0, 32'h11, 32'h22, 1'b0);
    e = last_of(0);
    wait_cyc(0, e + 2);
    a_v[0] = 32'h77; b_v[0] = 32'h01; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_cyc(0, e + 8);
    a_v[0] = 32'h40; b_v[0] = 32'h02; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    drain(0);

    // Reset in the middle of RUN aborts the operation
    issue(0, 32'h80, 32'h01, 1'b0);
    e = last_of(0);
    wait_cyc(0, e + 3);
    #2 rst_n = 1'b0;
    #1 chk("abort_outs", 0, 64'(outs_of(0)), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    issue(0, 32'h80, 32'h01, 1'b0);
    drain(0);

    // Back-to-back with start held high
    issue(0, 32'h9C, 32'h3A, 1'b1);
    issue(0, 32'h10, 32'hF0, 1'b1);
    issue(0, 32'h7F, 32'h7F, 1'b1);
    start_v[0] = 1'b0;
    drain(0);

    // Random WIDTH=8 pairs
    for (int i = 0; i < 10; i++) issue(0, 32'($urandom_range(255)), 32'($urandom_range(255)), 1'b0);
    drain(0);

    // Exhaustive WIDTH=2
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) issue(1, 32'(i), 32'(j), 1'b0);
    drain(1);

    // WIDTH=32 extremes plus random pairs
    issue(2, 32'h00000000, 32'h00000001, 1'b0);
    issue(2, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    issue(2, 32'h80000000, 32'h7FFFFFFF, 1'b0);
    for (int i = 0; i < 3; i++) issue(2, $urandom(), $urandom(), 1'b0);
    drain(2);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `a - b` one bit per clock, LSB first, with a single borrow flip-flop. It performs the inverse of the combinational full-adder path: ripple arithmetic is traded for a `WIDTH`-cycle latency and a start/done handshake. It sits behind a register-mapped or FSM-driven controller that needs area-cheap subtraction.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `a` in WIDTH: minuend; captured on the accepting edge.
- `b` in WIDTH: subtrahend; captured on the accepting edge.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle completion pulse, high in DONE.
- `diff` out WIDTH: `(a - b) mod 2^WIDTH`; holds the last completed result.
- `borrow_out` out 1: 1 when unsigned `a < b`; holds the last completed result.

## Operation
- FSM has three states: IDLE, RUN and DONE.
- IDLE -> RUN on an edge with `start=1`:
  - load shift registers `sa<=a` and `sb<=b`;
  - clear the borrow flop `br<=0`;
  - clear bit counter `cnt<=0`.
- RUN, each edge, with `x=sa[0]` and `y=sb[0]`:
  - result bit `d = x^y^br`;
  - `br <= (~x & y) | (~(x^y) & br)`;
  - shift `d` into the MSB of internal result register `sr`;
  - shift `sa` and `sb` right by 1;
  - `cnt <= cnt+1`.
- RUN -> DONE on the edge that processes bit WIDTH-1 (`cnt==WIDTH-1`). On that same edge:
  - `diff` takes the final `sr` contents, including the bit being shifted in;
  - `borrow_out` takes the final borrow.
- DONE -> IDLE unconditionally on the next edge.
- `diff` and `borrow_out` change only on the completion edge; they are stable during RUN.
- `start` is ignored in RUN and DONE. Nothing is queued and no error is flagged.
- `a` and `b` may change freely after the accepting edge.
- `start` held high continuously gives back-to-back operations, one every WIDTH+2 cycles.

## Timing
- Reset asserted, asynchronous and at any time:
  - state=IDLE;
  - `busy=0`, `done=0`, `diff=0`, `borrow_out=0`;
  - `sa`, `sb`, `sr`, `br` and `cnt` all cleared.
- Reset mid-RUN aborts the operation: no `done` pulse, and outputs go to 0.
- Reset deassertion can be asynchronous. The first edge with `rst_n=1` may accept `start`.
- Latency, with `start` accepted at edge E:
  - `busy` is high from E through E+WIDTH−1;
  - `done` is high for exactly the cycle between edges E+WIDTH and E+WIDTH+1;
  - results are valid from edge E+WIDTH onward.
- `busy` and `done` are never high together. `done` is registered, not combinational from `start`.
- Wrap-around: the result is modulo 2^WIDTH. The borrow from the MSB goes only to `borrow_out`.

## Test plan
- Basic subtract, WIDTH=8: reset, then start with a=0x05, b=0x03 -> `done` exactly 8 cycles after the accept edge, diff=0x02, borrow_out=0, busy high for 8 cycles.
- Borrow and wrap-around:
  - a=0x03, b=0x05 -> diff=0xFE, borrow_out=1;
  - a=0x00, b=0x01 -> diff=0xFF, borrow_out=1;
  - a=0xFF, b=0xFF -> diff=0x00, borrow_out=0.
- Ignored start: pulse `start` with new operands during RUN and again in DONE -> the result matches the original operands; exactly one `done`; IDLE reached.
- Reset abort: assert rst_n=0 at RUN cycle 3 of a=0x80, b=0x01 -> all outputs 0 immediately, no `done`; a following start with a=0x80, b=0x01 -> diff=0x7F, borrow_out=0.
- Back-to-back: `start` held high across three operand pairs -> accepts 10 cycles apart (WIDTH+2), one `done` per operation, and `diff` stable between completions.
- Random: 10 `$random` operand pairs -> diff == (a-b)&0xFF and borrow_out == (a<b), checked in each `done` cycle; repeat with WIDTH=2 (exhaustive, 16 pairs) and WIDTH=32 using 0x00000000 - 0x00000001 -> 0xFFFFFFFF, borrow 1.
